// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: width codes, FSM states,
// holding/WB payload records and the byte-enable helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Operation captured when a memory access is accepted.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] valu;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [3:0]  be;
    logic [2:0]  f3;
    logic        rw;
    logic        mtr;
    logic        mr;
    logic        we;
  } hold_t;

  // MEM/WB pipeline register payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] valu;
    logic [31:0] instr;
    logic [31:0] mdata;
    logic [4:0]  rd;
    logic        rw;
    logic        mtr;
    logic        flt;
  } wb_t;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: byte_en = 4'b0001 << a;
      F3_H, F3_HU: byte_en = a[1] ? 4'b1100 : 4'b0011;
      F3_W:        byte_en = 4'b1111;
      default:     byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Load-data extractor: picks the addressed byte/half and sign- or zero-extends.
module lsu_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension by width code.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    data_o = rdata_i;
      F3_BU:   data_o = {24'h000000, byte_sel};
      F3_HU:   data_o = {16'h0000, half_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage and MEM/WB register: request/ready data-memory handshake,
// fault detection, ready timeout and registered pass-through to WB.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] VALUResult_i,
  input  logic [31:0] RDData_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i,
  output logic        stall_o,
  output logic [31:0] pc_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] VALUResult_o,
  output logic [31:0] instr_o,
  output logic [31:0] MemData_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic        mem_fault_o
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  hold_t       hold_q, hold_d;
  wb_t         wb_q, wb_d;

  logic [2:0]  f3;
  logic        bad;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic [16:0] cnt_inc;

  assign f3      = instr_i[14:12];
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  lsu_align u_align (
    .rdata_i   (dmem_rdata_i),
    .addr_lo_i (hold_q.alu[1:0]),
    .funct3_i  (hold_q.f3),
    .data_o    (load_data)
  );

  // Legality of the incoming access and lane-replicated store data.
  always_comb begin
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = ALUResult_i[0];
      F3_W:    bad = |ALUResult_i[1:0];
      F3_BU:   bad = MemWrite_i;
      F3_HU:   bad = MemWrite_i | ALUResult_i[0];
      default: bad = 1'b1;
    endcase
    if (MemRead_i && MemWrite_i) bad = 1'b1;
    case (f3)
      F3_B:    wdata = {4{RDData_i[7:0]}};
      F3_H:    wdata = {2{RDData_i[15:0]}};
      default: wdata = RDData_i;
    endcase
  end

  // Next-state, holding registers, WB payload and stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    wb_d    = wb_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        wb_d = '{pc: pc_i, alu: ALUResult_i, valu: VALUResult_i, instr: instr_i,
                 mdata: '0, rd: RDaddr_i, rw: RegWrite_i, mtr: MemToReg_i, flt: 1'b0};
        if (MemRead_i || MemWrite_i) begin
          if (bad) begin
            wb_d.rw  = 1'b0;
            wb_d.flt = 1'b1;
          end else begin
            stall_o = 1'b1;
            state_d = BUSY;
            cnt_d   = '0;
            hold_d  = '{pc: pc_i, alu: ALUResult_i, valu: VALUResult_i, instr: instr_i,
                        wdata: wdata, rd: RDaddr_i, be: byte_en(f3, ALUResult_i[1:0]),
                        f3: f3, rw: RegWrite_i, mtr: MemToReg_i, mr: MemRead_i,
                        we: MemWrite_i};
            wb_d.rw    = 1'b0;
            wb_d.mtr   = 1'b0;
            wb_d.instr = '0;
          end
        end
      end
      BUSY: begin
        stall_o = !dmem_ready_i;
        if (dmem_ready_i || cnt_inc == 17'(MAX_WAIT)) begin
          // A timeout is the last waiting cycle: stall is released and the
          // held instruction retires with a fault instead of load data.
          stall_o = 1'b0;
          state_d = IDLE;
          wb_d    = '{pc: hold_q.pc, alu: hold_q.alu, valu: hold_q.valu,
                      instr: hold_q.instr, mdata: '0, rd: hold_q.rd,
                      rw: hold_q.rw, mtr: hold_q.mtr, flt: 1'b0};
          if (dmem_ready_i) begin
            if (hold_q.mr) wb_d.mdata = load_data;
          end else begin
            wb_d.rw  = 1'b0;
            wb_d.flt = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, holding and MEM/WB registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      wb_q    <= wb_d;
    end
  end

  assign dmem_req_o   = (state_q == BUSY);
  assign dmem_we_o    = hold_q.we;
  assign dmem_addr_o  = {hold_q.alu[31:2], 2'b00};
  assign dmem_be_o    = hold_q.be;
  assign dmem_wdata_o = hold_q.wdata;

  assign pc_o         = wb_q.pc;
  assign ALUResult_o  = wb_q.alu;
  assign VALUResult_o = wb_q.valu;
  assign instr_o      = wb_q.instr;
  assign MemData_o    = wb_q.mdata;
  assign RDaddr_o     = wb_q.rd;
  assign RegWrite_o   = wb_q.rw;
  assign MemToReg_o   = wb_q.mtr;
  assign mem_fault_o  = wb_q.flt;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected WB results are queued when an
// operation is driven and compared when the stage retires it.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i, pc_i, ALUResult_i, VALUResult_i, RDData_i;
  logic [4:0]  RDaddr_i;
  logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        dmem_ready_i;
  logic        stall_o;
  logic [31:0] pc_o, ALUResult_o, VALUResult_o, instr_o, MemData_o;
  logic [4:0]  RDaddr_o;
  logic        RegWrite_o, MemToReg_o, mem_fault_o;

  typedef struct {
    logic [31:0] pc, alu, valu, instr, md;
    logic [4:0]  rd;
    logic        rw, mtr, flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   op_n    = 0;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i),
    .ALUResult_i(ALUResult_i), .VALUResult_i(VALUResult_i), .RDData_i(RDData_i),
    .RDaddr_i(RDaddr_i), .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
    .dmem_ready_i(dmem_ready_i), .stall_o(stall_o), .pc_o(pc_o),
    .ALUResult_o(ALUResult_o), .VALUResult_o(VALUResult_o), .instr_o(instr_o),
    .MemData_o(MemData_o), .RDaddr_o(RDaddr_o), .RegWrite_o(RegWrite_o),
    .MemToReg_o(MemToReg_o), .mem_fault_o(mem_fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    instr_i = '0; pc_i = '0; ALUResult_i = '0; VALUResult_i = '0; RDData_i = '0;
    RDaddr_i = '0; RegWrite_i = 0; MemToReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
    dmem_ready_i = 0; dmem_rdata_i = '0;
  endtask

  // Drive one operation, play the memory with ready after lat cycles
  // (lat = 0: never ready), then compare the retired WB payload.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] addr, sdata, rdata,
                        input logic rw, mtr, mr, mw, input int lat,
                        input logic [31:0] e_md, input logic e_rw, e_flt,
                        input int e_stall, e_req,
                        input logic [3:0] e_be, input logic [31:0] e_wd);
    exp_t e, g;
    int   stalls = 0;
    int   reqs   = 0;
    bit   done   = 0;
    op_n++;
    @(negedge clk);
    instr_i      = {12'h000, 5'd0, f3, 5'(op_n + 4), 7'b0000011};
    pc_i         = 32'h1000 + 32'(op_n * 4);
    ALUResult_i  = addr;
    VALUResult_i = ~addr;
    RDData_i     = sdata;
    RDaddr_i     = 5'(op_n + 4);
    RegWrite_i   = rw; MemToReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
    e.pc = pc_i; e.alu = addr; e.valu = ~addr; e.instr = instr_i; e.md = e_md;
    e.rd = RDaddr_i; e.rw = e_rw; e.mtr = mtr; e.flt = e_flt;
    exp_q.push_back(e);
    for (int c = 0; c < 32 && !done; c++) begin
      if (c > 0) @(negedge clk);
      dmem_ready_i = (lat > 0 && c == lat);
      dmem_rdata_i = dmem_ready_i ? rdata : 32'h0BAD_0BAD;
      #1;
      if (stall_o) stalls++;
      if (dmem_req_o) begin
        if (reqs == 0) begin
          chk({tag, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
          chk({tag, " be"}, 32'(dmem_be_o), 32'(e_be));
          chk({tag, " wdata"}, dmem_wdata_o, e_wd);
          chk({tag, " we"}, 32'(dmem_we_o), 32'(mw));
          chk({tag, " bubble rw"}, 32'(RegWrite_o), 32'd0);
          chk({tag, " bubble instr"}, instr_o, 32'd0);
        end
        reqs++;
      end
      if (!stall_o) begin
        @(posedge clk);
        #1;
        dmem_ready_i = 0;
        done = 1;
      end
    end
    chk({tag, " retired"}, 32'(done), 32'd1);
    chk({tag, " stall cycles"}, 32'(stalls), 32'(e_stall));
    chk({tag, " req cycles"}, 32'(reqs), 32'(e_req));
    g = exp_q.pop_front();
    chk({tag, " pc"}, pc_o, g.pc);
    chk({tag, " alu"}, ALUResult_o, g.alu);
    chk({tag, " valu"}, VALUResult_o, g.valu);
    chk({tag, " instr"}, instr_o, g.instr);
    chk({tag, " mdata"}, MemData_o, g.md);
    chk({tag, " rd"}, 32'(RDaddr_o), 32'(g.rd));
    chk({tag, " rw"}, 32'(RegWrite_o), 32'(g.rw));
    chk({tag, " mtr"}, 32'(MemToReg_o), 32'(g.mtr));
    chk({tag, " fault"}, 32'(mem_fault_o), 32'(g.flt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_i = 1;
    repeat (2) @(negedge clk);
    chk("reset req", 32'(dmem_req_o), 32'd0);
    chk("reset stall", 32'(stall_o), 32'd0);
    chk("reset rw", 32'(RegWrite_o), 32'd0);
    chk("reset fault", 32'(mem_fault_o), 32'd0);
    chk("reset alu", ALUResult_o, 32'd0);
    rst_i = 0;

    //      tag     f3      addr          sdata         rdata         rw mtr mr mw lat  mdata         rw flt st rq be       wdata
    run_op("alu",   3'b000, 32'h0000_1234, 32'h0,        32'h0,        1, 0, 0, 0, 1,  32'h0,        1, 0, 0, 0, 4'b0000, 32'h0);
    run_op("lb",    3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 1, 1, 0, 3, 32'hFFFF_FF80, 1, 0, 3, 3, 4'b1000, 32'h0);
    run_op("lbu",   3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 1, 1, 0, 3, 32'h0000_0080, 1, 0, 3, 3, 4'b1000, 32'h0);
    run_op("sh",    3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0,       0, 0, 0, 1, 1, 32'h0,        0, 0, 1, 1, 4'b1100, 32'hABCD_ABCD);
    run_op("lh",    3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 1, 1, 1, 0, 2, 32'hFFFF_8001, 1, 0, 2, 2, 4'b1100, 32'h0);
    run_op("lhu",   3'b101, 32'h0000_0100, 32'h0,        32'h8001_F00D, 1, 1, 1, 0, 1, 32'h0000_F00D, 1, 0, 1, 1, 4'b0011, 32'h0);
    run_op("lw",    3'b010, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 1, 1, 1, 0, 2, 32'hDEAD_BEEF, 1, 0, 2, 2, 4'b1111, 32'h0);
    run_op("sb",    3'b000, 32'h0000_0101, 32'h1234_565A, 32'h0,       0, 0, 0, 1, 1, 32'h0,        0, 0, 1, 1, 4'b0010, 32'h5A5A_5A5A);
    run_op("sw",    3'b010, 32'h0000_0108, 32'hCAFE_F00D, 32'h0,       0, 0, 0, 1, 3, 32'h0,        0, 0, 3, 3, 4'b1111, 32'hCAFE_F00D);
    run_op("lb+",   3'b000, 32'h0000_0102, 32'h0,        32'h0012_3456, 1, 1, 1, 0, 1, 32'h0000_0012, 1, 0, 1, 1, 4'b0100, 32'h0);
    run_op("lw mis",3'b010, 32'h0000_0101, 32'h0,        32'h0,        1, 1, 1, 0, 1,  32'h0,        0, 1, 0, 0, 4'b0000, 32'h0);
    run_op("rd+wr", 3'b010, 32'h0000_0100, 32'h0,        32'h0,        1, 1, 1, 1, 1,  32'h0,        0, 1, 0, 0, 4'b0000, 32'h0);
    run_op("lh mis",3'b001, 32'h0000_0101, 32'h0,        32'h0,        1, 1, 1, 0, 1,  32'h0,        0, 1, 0, 0, 4'b0000, 32'h0);
    run_op("f3 011",3'b011, 32'h0000_0100, 32'h0,        32'h0,        1, 1, 1, 0, 1,  32'h0,        0, 1, 0, 0, 4'b0000, 32'h0);
    run_op("st bu", 3'b100, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 0, 1, 1,  32'h0,        0, 1, 0, 0, 4'b0000, 32'h0);
    run_op("alu2",  3'b000, 32'h0000_5678, 32'h0,        32'h0,        1, 0, 0, 0, 1,  32'h0,        1, 0, 0, 0, 4'b0000, 32'h0);
    run_op("tmo",   3'b010, 32'h0000_0100, 32'h0,        32'h0,        1, 1, 1, 0, 0,  32'h0,        0, 1, 4, 4, 4'b1111, 32'h0);
    run_op("lb2",   3'b000, 32'h0000_0100, 32'h0,        32'h0000_00C3, 1, 1, 1, 0, 1, 32'hFFFF_FFC3, 1, 0, 1, 1, 4'b0001, 32'h0);

    // Asynchronous reset while an access is outstanding.
    @(negedge clk);
    instr_i = {12'h000, 5'd0, 3'b010, 5'd9, 7'b0000011};
    pc_i = 32'h2000; ALUResult_i = 32'h0000_0300; RDaddr_i = 5'd9;
    RegWrite_i = 1; MemToReg_i = 1; MemRead_i = 1; MemWrite_i = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("busy req", 32'(dmem_req_o), 32'd1);
    rst_i = 1;
    idle_inputs();
    #1;
    chk("rst req", 32'(dmem_req_o), 32'd0);
    chk("rst stall", 32'(stall_o), 32'd0);
    chk("rst addr", dmem_addr_o, 32'd0);
    chk("rst be", 32'(dmem_be_o), 32'd0);
    chk("rst pc", pc_o, 32'd0);
    chk("rst fault", 32'(mem_fault_o), 32'd0);
    @(negedge clk);
    rst_i = 0;
    run_op("post rst", 3'b000, 32'h0000_9ABC, 32'h0, 32'h0, 1, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 4'b0000, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage between the EX/MEM pipeline register and the WB stage. It decodes load/store width from the instruction, drives a word-addressed data-memory request/ready handshake with byte enables, and aligns and extends load data. It stalls the upstream pipeline while an access is outstanding and registers the MEM/WB payload, which makes it the MEM/WB pipeline register.

## Interface
- MAX_WAIT, 255: ready timeout in cycles. Legal range 1–65535.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- instr_i  in  32  instruction; funct3 = instr_i[14:12]
- pc_i, ALUResult_i, VALUResult_i  in  32 each  from EX/MEM; ALUResult_i is the effective address
- RDData_i  in  32  store data
- RDaddr_i  in  5  destination register
- RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i  in  1 each  control
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_rdata_i  in  32  read data; valid only when dmem_ready_i = 1
- dmem_ready_i  in  1  access complete
- stall_o  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM
- pc_o, ALUResult_o, VALUResult_o, instr_o  out  32 each  registered pass-through to WB
- MemData_o  out  32  aligned and extended load data
- RDaddr_o  out  5;  RegWrite_o, MemToReg_o  out  1 each
- mem_fault_o  out  1  registered; marks a misaligned, illegal or timed-out access

## Operation
- States: IDLE and BUSY.
- IDLE, no memory op (MemRead_i = MemWrite_i = 0):
  - inputs are registered straight to the WB outputs each cycle
  - MemData_o = 0, mem_fault_o = 0
- IDLE, legal memory op:
  - stall_o = 1
  - capture address, funct3, store data and control into internal holding registers
  - drive dmem_* from the registered values and go to BUSY
  - WB outputs load a bubble: RegWrite_o = MemToReg_o = 0, instr_o = 0, fault 0
- BUSY:
  - dmem_req_o = 1; all dmem_* outputs stay stable until ready
  - stall_o = !dmem_ready_i
  - on ready: WB outputs load the held instruction; loads write MemData_o; go to IDLE and drop req
  - inputs are ignored in BUSY
- Widths, by funct3:
  - 000 LB/SB: be = 1<<addr[1:0]; wdata = {4{d[7:0]}}
  - 001 LH/SH: be = addr[1] ? 1100 : 0011; wdata = {2{d[15:0]}}
  - 010 LW/SW: be = 1111
  - 100 LBU, 101 HU: loads only
- Load data: select the byte or half at addr[1:0], then sign-extend (000/001) or zero-extend (100/101).
- Fault conditions, checked in IDLE. Any of these issues no request and no stall, registers mem_fault_o = 1 with the instruction, and forces RegWrite_o = 0:
  - halfword with addr[0] = 1
  - word with addr[1:0] ≠ 0
  - undefined funct3, or 100/101 on a store
  - MemRead_i and MemWrite_i both 1
- Timeout:
  - a 16-bit wait counter clears on entering BUSY and counts each cycle with ready = 0
  - when it reaches MAX_WAIT, abort: drop req, go to IDLE, stall_o = 0 that cycle, register mem_fault_o = 1 and RegWrite_o = 0
- Reset, including mid-BUSY:
  - state IDLE, counter 0, all outputs 0, dmem_req_o drops immediately
  - memory tolerates an abandoned request

## Timing
- Non-memory instruction: 1-cycle latency to the WB outputs.
- Memory op accepted in cycle T:
  - req is high from T+1
  - with ready in T+k (k ≥ 1), the result appears on the WB outputs after the edge ending T+k
  - stall_o is high for cycles T..T+k−1
  - zero-wait memory (ready in T+1) costs one stall cycle
- Back-to-back memory ops: the next op is seen in IDLE at T+k+1, so there is no overlap.
- Fault or timeout: the result is registered in the same cycle it is detected.

## Structure
- Shared package `mem_pkg`:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum IDLE/BUSY
  - byte-enable helper function
- Sub-module `lsu_align`: combinational load extractor and extender, taking rdata, addr[1:0] and funct3.
- FSM, holding registers, timeout counter and WB register all live in `mem_stage`.

## Test plan
- ALU op: RegWrite_i = 1, RDaddr_i = 5, ALUResult_i = 0x1234 → next cycle ALUResult_o = 0x1234, RDaddr_o = 5, stall_o never asserted.
- LB at addr 0x103, rdata 0x80FF_0000 returned 3 cycles after req → be = 1000, stall for 3 cycles, MemData_o = 0xFFFF_FF80; LBU gives 0x0000_0080.
- SH at 0x202, data 0x0000_ABCD, zero-wait → dmem_addr_o = 0x200, be = 1100, wdata = 0xABCD_ABCD, we = 1, one stall cycle.
- LW at 0x101 → no req, mem_fault_o = 1, RegWrite_o = 0; the same applies to MemRead_i = MemWrite_i = 1.
- MAX_WAIT = 4 and ready never asserted → req for 4 cycles, then fault with stall released; rst_i pulsed mid-BUSY → req drops asynchronously and all outputs are 0.
